// File: rtl/sram_axi_bridge.sv
// Bridges an SRAM-like cache port onto single-beat AXI read/write channels, one transaction in flight.
// Build option: define BRIDGE_POSTED_WRITE_EN to complete writes once both AW and W are accepted.
module sram_axi_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            size_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  arvalid_reg;
  logic                  rready_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  bready_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;

  logic [1:0] size_next;
  logic [3:0] wstrb_next;
  logic       aw_hs;
  logic       w_hs;
  logic       aw_fin;
  logic       w_fin;
  logic       rd_ok;
  logic       wr_ok;

  // Size 3 is folded into word so everything downstream only sees 0..2.
  always_comb begin
    size_next = (data_size == 2'd3) ? 2'd2 : data_size;
    case (size_next)
      2'd0:    wstrb_next = 4'b0001 << data_addr[1:0];
      2'd1:    wstrb_next = data_addr[1] ? 4'b1100 : 4'b0011;
      default: wstrb_next = 4'b1111;
    endcase
  end

  assign aw_hs  = awvalid_reg & awready;
  assign w_hs   = wvalid_reg & wready;
  assign aw_fin = aw_done_reg | aw_hs;
  assign w_fin  = w_done_reg | w_hs;
  assign rd_ok  = (state_reg == RD_DATA) & rvalid;

`ifdef BRIDGE_POSTED_WRITE_EN
  assign wr_ok = (state_reg == WR_REQ) & aw_fin & w_fin;
`else
  assign wr_ok = (state_reg == WR_RESP) & bvalid;
`endif

  // Gated by rst so the cache sees no accept while reset is held.
  assign data_addr_ok = data_req & (state_reg == IDLE) & rst;
  assign data_data_ok = rd_ok | wr_ok;
  assign data_rdata   = rd_ok ? rdata : 32'd0;

  assign araddr  = addr_reg;
  assign arsize  = {1'b0, size_reg};
  assign arvalid = arvalid_reg;
  assign rready  = rready_reg;
  assign awaddr  = addr_reg;
  assign awsize  = {1'b0, size_reg};
  assign awvalid = awvalid_reg;
  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wvalid  = wvalid_reg;
  assign bready  = bready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      size_reg    <= 2'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'd0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_req) begin
            addr_reg    <= data_addr;
            size_reg    <= size_next;
            wdata_reg   <= data_wdata;
            wstrb_reg   <= wstrb_next;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            if (data_wr) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once both have been taken.
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomised self-checking bench for sram_axi_bridge: acts as cache master and AXI slave memory.
module tb_sram_axi_bridge;
  localparam int AW = 32;

`ifdef BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_req = 1'b0;
  logic          data_wr = 1'b0;
  logic [1:0]    data_size = 2'd0;
  logic [AW-1:0] data_addr = '0;
  logic [31:0]   data_wdata = 32'd0;
  logic [31:0]   data_rdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [AW-1:0] araddr;
  logic [2:0]    arsize;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [31:0]   rdata = 32'd0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awsize;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic          bvalid = 1'b0;
  logic          bready;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  sram_axi_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave-side memory (written through AXI) and reference memory (written from the request).
  logic [31:0] slave_mem [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] init_word(int w);
    return 32'(w) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] slave_rd(int w);
    return slave_mem.exists(w) ? slave_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Bytes covered by an access: naturally aligned group of 1, 2 or 4 bytes around addr.
  function automatic logic [3:0] ref_strb(logic [1:0] size, logic [31:0] addr);
    int nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int lo = (int'(addr % 4) / nb) * nb;
    logic [3:0] s = 4'd0;
    for (int b = 0; b < 4; b++) s[b] = (b >= lo) && (b < lo + nb);
    return s;
  endfunction

  // Results of the most recent do_txn, cycle numbers relative to the request cycle.
  int t_acc, t_ar, t_aw, t_w, t_r, t_b, t_ok, n_ok, aw_hi, w_hi, acc_abs;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, cap_rdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;

  task automatic do_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int ar_d, input int aw_d, input int w_d,
                        input int r_d, input int b_d);
    int ar_c = 0, aw_c = 0, w_c = 0, r_c = 0, b_c = 0, cyc = 0;
    bit finished = 0, stable_bad = 0, late_ok = 0;
    bit pv_ar = 0, pv_aw = 0, pv_w = 0;
    logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;
    logic [3:0]  p_wstrb = 0;
    logic [1:0]  exp_sz = (size == 2'd3) ? 2'd2 : size;
    int exp_aw = 1 + aw_d, exp_w = 1 + w_d;
    int exp_done = (exp_aw > exp_w) ? exp_aw : exp_w;
    int exp_b = exp_done + 1 + b_d;
    int exp_ok = POSTED ? exp_done : exp_b;
    logic [3:0] rs = ref_strb(size, addr);
    logic [31:0] rw;
    t_acc = -1; t_ar = -1; t_aw = -1; t_w = -1; t_r = -1; t_b = -1; t_ok = -1;
    n_ok = 0; aw_hi = 0; w_hi = 0; acc_abs = -1;
    cap_araddr = 0; cap_awaddr = 0; cap_wdata = 0; cap_rdata = 0;
    cap_arsize = 0; cap_awsize = 0; cap_wstrb = 0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      if (pv_ar && (!arvalid || araddr !== p_araddr)) stable_bad = 1;
      if (pv_aw && (!awvalid || awaddr !== p_awaddr)) stable_bad = 1;
      if (pv_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) stable_bad = 1;
      data_req = 1'b1;
      if (t_acc < 0) begin
        data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
      end else begin
        data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      arready = arvalid && (ar_c >= ar_d); if (arvalid) ar_c++;
      awready = awvalid && (aw_c >= aw_d); if (awvalid) begin aw_c++; aw_hi++; end
      wready  = wvalid && (w_c >= w_d);    if (wvalid) begin w_c++; w_hi++; end
      rvalid  = rready && (r_c >= r_d);    if (rready) r_c++;
      rdata   = rvalid ? slave_rd(int'(cap_araddr >> 2)) : $urandom;
      bvalid  = bready && (b_c >= b_d);    if (bready) b_c++;
      #1;
      if (t_acc < 0) begin
        if (data_addr_ok) begin t_acc = cyc; acc_abs = cyc_cnt; end
      end else if (data_addr_ok) late_ok = 1;
      if (arvalid && arready) begin t_ar = cyc; cap_araddr = araddr; cap_arsize = arsize; end
      if (awvalid && awready) begin t_aw = cyc; cap_awaddr = awaddr; cap_awsize = awsize; end
      if (wvalid && wready) begin t_w = cyc; cap_wdata = wdata; cap_wstrb = wstrb; end
      if (rvalid && rready) t_r = cyc;
      if (bvalid && bready) begin
        t_b = cyc;
        rw = slave_rd(int'(cap_awaddr >> 2));
        for (int b = 0; b < 4; b++) if (cap_wstrb[b]) rw[8*b +: 8] = cap_wdata[8*b +: 8];
        slave_mem[int'(cap_awaddr >> 2)] = rw;
      end
      if (data_data_ok) begin n_ok++; t_ok = cyc; cap_rdata = data_rdata; end
      pv_ar = arvalid && !arready; p_araddr = araddr;
      pv_aw = awvalid && !awready; p_awaddr = awaddr;
      pv_w  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
      finished = wr ? (t_b >= 0) : (t_r >= 0);
      cyc++;
    end
    checks++; if (!finished) begin errors++; $display("FAIL txn_timeout: got %0d cycles required completion", cyc); end
    checks++; if (t_acc !== 0) begin errors++; $display("FAIL accept_cycle: got %0d required 0", t_acc); end
    checks++; if (n_ok !== 1) begin errors++; $display("FAIL data_ok_count: got %0d required 1", n_ok); end
    checks++; if (late_ok !== 1'b0) begin errors++; $display("FAIL addr_ok_busy: got %0b required 0", late_ok); end
    checks++; if (stable_bad !== 1'b0) begin errors++; $display("FAIL valid_stable: got %0b required 0", stable_bad); end
    if (!wr) begin
      checks++; if (t_ar !== 1 + ar_d) begin errors++; $display("FAIL ar_cycle: got %0d required %0d", t_ar, 1 + ar_d); end
      checks++; if (cap_araddr !== addr) begin errors++; $display("FAIL araddr: got %h required %h", cap_araddr, addr); end
      checks++; if (cap_arsize !== {1'b0, exp_sz}) begin errors++; $display("FAIL arsize: got %0d required %0d", cap_arsize, exp_sz); end
      checks++; if (t_ok !== 2 + ar_d + r_d) begin errors++; $display("FAIL rd_ok_cycle: got %0d required %0d", t_ok, 2 + ar_d + r_d); end
      checks++; if (cap_rdata !== ref_rd(int'(addr >> 2))) begin errors++; $display("FAIL rd_data: got %h required %h", cap_rdata, ref_rd(int'(addr >> 2))); end
      $display("txn rd addr=%h size=%0d data=%h ok@%0d", addr, size, cap_rdata, t_ok);
    end else begin
      checks++; if (t_aw !== exp_aw) begin errors++; $display("FAIL aw_cycle: got %0d required %0d", t_aw, exp_aw); end
      checks++; if (t_w !== exp_w) begin errors++; $display("FAIL w_cycle: got %0d required %0d", t_w, exp_w); end
      checks++; if (cap_awaddr !== addr) begin errors++; $display("FAIL awaddr: got %h required %h", cap_awaddr, addr); end
      checks++; if (cap_awsize !== {1'b0, exp_sz}) begin errors++; $display("FAIL awsize: got %0d required %0d", cap_awsize, exp_sz); end
      checks++; if (cap_wdata !== wd) begin errors++; $display("FAIL wdata: got %h required %h", cap_wdata, wd); end
      checks++; if (cap_wstrb !== rs) begin errors++; $display("FAIL wstrb: got %b required %b", cap_wstrb, rs); end
      checks++; if (t_b !== exp_b) begin errors++; $display("FAIL b_cycle: got %0d required %0d", t_b, exp_b); end
      checks++; if (t_ok !== exp_ok) begin errors++; $display("FAIL wr_ok_cycle: got %0d required %0d", t_ok, exp_ok); end
      rw = ref_rd(int'(addr >> 2));
      for (int b = 0; b < 4; b++) if (rs[b]) rw[8*b +: 8] = wd[8*b +: 8];
      ref_mem[int'(addr >> 2)] = rw;
      $display("txn wr addr=%h size=%0d wdata=%h strb=%b ok@%0d", addr, size, wd, cap_wstrb, t_ok);
    end
  endtask

  task automatic quiet_inputs();
    data_req = 0; data_wr = 0; arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    data_req = 1; arready = 1; awready = 1; wready = 1; rvalid = 1; bvalid = 1; rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'd0) begin errors++; $display("FAIL reset_valids: got %b required 00000", {arvalid, awvalid, wvalid, rready, bready}); end
    checks++; if ({data_addr_ok, data_data_ok} !== 2'd0) begin errors++; $display("FAIL reset_oks: got %b required 00", {data_addr_ok, data_data_ok}); end
    checks++; if ({araddr, wdata, wstrb, data_rdata} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%b/%h required zeros", araddr, wdata, wstrb, data_rdata); end
    quiet_inputs();
    rst = 1;
    $display("txn reset released");
  endtask

  task automatic test_read_word();
    slave_mem[int'(32'h1FC0_0100 >> 2)] = 32'hDEAD_BEEF;
    ref_mem[int'(32'h1FC0_0100 >> 2)] = 32'hDEAD_BEEF;
    do_txn(1'b0, 2'd2, 32'h1FC0_0100, 32'd0, 0, 0, 0, 0, 0);
    checks++; if (cap_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_word_data: got %h required deadbeef", cap_rdata); end
    checks++; if (t_ok !== 2) begin errors++; $display("FAIL read_word_ok: got %0d required 2", t_ok); end
  endtask

  task automatic test_write_byte();
    do_txn(1'b1, 2'd0, 32'h0000_0013, 32'hAA00_0000, 0, 2, 0, 0, 1);
    checks++; if (cap_wstrb !== 4'b1000) begin errors++; $display("FAIL byte_wstrb: got %b required 1000", cap_wstrb); end
    checks++; if (w_hi !== 1) begin errors++; $display("FAIL byte_wvalid_len: got %0d required 1", w_hi); end
    checks++; if (aw_hi !== 3) begin errors++; $display("FAIL byte_awvalid_len: got %0d required 3", aw_hi); end
    checks++; if (t_ok !== (POSTED ? 3 : 5)) begin errors++; $display("FAIL byte_ok_cycle: got %0d required %0d", t_ok, POSTED ? 3 : 5); end
    do_txn(1'b0, 2'd2, 32'h0000_0010, 32'd0, 0, 0, 0, 0, 0);
    checks++; if (cap_rdata[31:24] !== 8'hAA) begin errors++; $display("FAIL byte_readback: got %h required aa", cap_rdata[31:24]); end
  endtask

  task automatic test_write_half_same_cycle();
    do_txn(1'b1, 2'd1, 32'h0000_0022, 32'h5566_7788, 0, 0, 0, 0, 0);
    checks++; if (cap_wstrb !== 4'b1100) begin errors++; $display("FAIL half_wstrb: got %b required 1100", cap_wstrb); end
    checks++; if (t_b !== 2) begin errors++; $display("FAIL half_single_wr_req: got b@%0d required 2", t_b); end
  endtask

  task automatic test_back_to_back();
    int first;
    do_txn(1'b0, 2'd2, 32'h0000_0104, 32'd0, 0, 0, 0, 0, 0);
    first = acc_abs;
    do_txn(1'b0, 2'd0, 32'h0000_0109, 32'd0, 0, 0, 0, 0, 0);
    checks++; if (acc_abs - first !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d required 3", acc_abs - first); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    quiet_inputs(); data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h40;
    @(negedge clk);
    quiet_inputs(); arready = 1;
    @(negedge clk);
    quiet_inputs(); rvalid = 1; rdata = 32'h1357_9BDF;
    #1 rst = 0;
    #1;
    checks++; if ({arvalid, rready, data_data_ok} !== 3'd0) begin errors++; $display("FAIL mid_reset_outputs: got %b required 000", {arvalid, rready, data_data_ok}); end
    checks++; if (data_rdata !== 32'd0) begin errors++; $display("FAIL mid_reset_rdata: got %h required 0", data_rdata); end
    repeat (2) @(negedge clk);
    quiet_inputs(); rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      quiet_inputs();
      #1;
      checks++; if ({data_data_ok, rready, arvalid} !== 3'd0) begin errors++; $display("FAIL post_reset_quiet: got %b required 000", {data_data_ok, rready, arvalid}); end
    end
    @(negedge clk);
    data_req = 1;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b required 1", data_addr_ok); end
    data_req = 0;
    $display("txn reset during read handled");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit wr = 1'($urandom);
      logic [1:0] sz = 2'($urandom);
      logic [31:0] a = 32'h200 + 32'($urandom_range(0, 127));
      do_txn(wr, sz, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    // Read back every touched word so stale or mis-strobed writes surface.
    for (int w = 32'h200 >> 2; w <= (32'h27F >> 2); w++)
      do_txn(1'b0, 2'd2, 32'(w) << 2, 32'd0, 0, 0, 0, $urandom_range(0, 2), 0);
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_write_byte();
    test_write_half_same_cycle();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    @(negedge clk);
    quiet_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the SRAM-like address and of araddr/awaddr.
REQ-002 Clocking: one clock; reset is asynchronous and active-low. Ports clk and rst follow the codebase names; rst is asserted at 0.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 data_req  in  1  SRAM-like request valid, driven by the cache.
REQ-006 data_wr  in  1  1 = write, 0 = read.
REQ-007 data_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-008 data_addr  in  ADDR_WIDTH  byte address.
REQ-009 data_wdata  in  32  write data, byte lanes in place.
REQ-010 data_rdata  out  32  read data; valid only while data_ok=1.
REQ-011 data_addr_ok  out  1  request accepted this cycle.
REQ-012 data_data_ok  out  1  transaction complete this cycle; one-cycle pulse.
REQ-013 AXI read-address channel:
- araddr  out  ADDR_WIDTH
- arsize  out  3
- arvalid  out  1
- arready  in  1
REQ-014 AXI read-data channel:
- rdata  in  32
- rvalid  in  1
- rready  out  1
REQ-015 AXI write-address channel:
- awaddr  out  ADDR_WIDTH
- awsize  out  3
- awvalid  out  1
- awready  in  1
REQ-016 AXI write-data channel:
- wdata  out  32
- wstrb  out  4
- wvalid  out  1
- wready  in  1
REQ-017 AXI write-response channel:
- bvalid  in  1
- bready  out  1
REQ-018 Single-beat transfers only; len/burst/id are not ports and are tied (len 0, INCR, id 0) in the wrapper.

Function
REQ-019 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one transaction outstanding.
REQ-020 data_addr_ok = data_req & (state==IDLE), combinational.
REQ-021 On accept, register wr, size, addr and wdata; the bridge ignores the inputs until the next IDLE.
REQ-022 On accept, next state is WR_REQ if wr=1, otherwise RD_ADDR.
REQ-023 RD_ADDR: arvalid=1 with registered araddr and arsize={1'b0,size}; on arready=1 go to RD_DATA.
REQ-024 RD_DATA: rready=1.
- On rvalid=1: data_data_ok=1 and data_rdata=rdata in the same cycle (combinational pass-through); next state IDLE.
REQ-025 WR_REQ: awvalid and wvalid both assert on WR_REQ entry.
- Each deasserts after its own handshake (flags aw_done, w_done); handshakes may occur in either order or in the same cycle.
- When both are done, go to WR_RESP.
REQ-026 wstrb (per Configuration below):
- Byte: 4'b0001 << addr[1:0].
- Half: addr[1] ? 4'b1100 : 4'b0011.
- Word: 4'b1111.
- wdata is the registered wdata, unshifted.
REQ-027 WR_RESP: bready=1; on bvalid=1 go to IDLE.
REQ-028 AXI valid/address/data/strb outputs stay stable while valid=1 and ready=0.
REQ-029 The earliest new addr_ok is the cycle after the cycle that returns to IDLE; back-to-back minimum read latency is 3 cycles (accept, AR, R).
REQ-030 Responses bresp/rresp are not checked; errors complete as OKAY.

Reset
REQ-031 rst=0 asynchronously forces IDLE and clears aw_done/w_done.
- All outputs go to 0, including arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok.
- Registered addr/size/wdata reset to 0.
REQ-032 Reset mid-transaction abandons it; no data_ok is issued. The interconnect is reset by the same rst.

Configuration
REQ-033 Macro BRIDGE_POSTED_WRITE_EN controls when a write completes.
- Defined: data_data_ok pulses in the cycle both aw and w handshakes are complete (posted write). WR_RESP still waits for bvalid, and addr_ok stays 0 until IDLE.
- Undefined: data_data_ok for writes pulses only in the WR_RESP cycle with bvalid=1.
- Read behaviour is identical in both builds.

Verification
REQ-034 Read word, addr 0x1FC0_0100, arready=1 and rvalid=1 with rdata 0xDEADBEEF one cycle later.
- addr_ok in cycle 0, arvalid in cycle 1 with araddr 0x1FC00100 and arsize 2.
- data_ok in cycle 2 with data_rdata 0xDEADBEEF.
REQ-035 Write byte, addr 0x0000_0013, wdata 0xAA000000, awready delayed 3 cycles, wready immediate.
- wstrb 4'b1000; wvalid drops after 1 cycle, awvalid held 3 cycles.
- bvalid, then data_ok (macro undefined).
REQ-036 Same write with BRIDGE_POSTED_WRITE_EN: data_ok in the awready cycle; a new req is accepted only after bvalid.
REQ-037 Write half, addr 0x...2, with awready and wready both high in the same cycle: wstrb 4'b1100 and a single-cycle WR_REQ.
REQ-038 rst driven low while in RD_DATA: arvalid/rready/data_ok go to 0 immediately (asynchronously); after release, no data_ok and the state is IDLE.
